// File: rtl/fp64_pkg.sv
// -----------------------------------------------------------------------------
// fp64_pkg
// Shared definitions for the binary64 multiplier back end: field widths, bias,
// special encodings, the operand class carried down the pipeline, flag bit
// positions and the stage-1 payload record.
// -----------------------------------------------------------------------------
package fp64_pkg;

    localparam int EXP_W  = 11;               // exponent field width
    localparam int MAN_W  = 52;               // stored fraction width
    localparam int BIAS   = 1023;             // exponent bias
    localparam int PROD_W = 2 * (MAN_W + 1);  // raw significand product width (106)
    localparam int E_W    = 14;               // signed working exponent width

    localparam logic [63:0]      QNAN_64 = 64'h7FF8_0000_0000_0000;
    localparam logic [EXP_W-1:0] INF_EXP = '1;

    // Operand class resolved in stage 1; specials bypass the rounding path.
    typedef enum logic [1:0] {
        CLS_NUM  = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_cls_e;

    // Bit positions inside flags = {invalid, overflow, underflow, inexact}.
    localparam int FLAG_INEXACT   = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_INVALID   = 3;

    // Everything stage 2 needs from stage 1.
    typedef struct packed {
        logic                   sign;
        fp_cls_e                cls;
        logic                   invalid;
        logic [MAN_W-1:0]       frac;
        logic                   g;
        logic                   st;
        logic signed [E_W-1:0]  e;
    } s1_t;

    // Special-operand priority: NaN (or inf*0) > inf > zero > ordinary number.
    function automatic fp_cls_e classify(input logic nan, input logic inf, input logic zero);
        if (nan || (inf && zero)) return CLS_NAN;
        else if (inf)             return CLS_INF;
        else if (zero)            return CLS_ZERO;
        else                      return CLS_NUM;
    endfunction

endpackage

// File: rtl/fp64_mul_norm_round_round.sv
// -----------------------------------------------------------------------------
// fp_round_rne
// Combinational round-to-nearest-even and range check for a normalised
// significand.
//   frac_i/g_i/st_i : 52-bit fraction, guard bit, sticky bit
//   e_i             : signed unbiased-plus-bias exponent before rounding
//   exp_o/frac_o    : packed exponent and fraction (inf or zero when out of range)
//   overflow_o/underflow_o/inexact_o : arithmetic flags for this result
// -----------------------------------------------------------------------------
module fp_round_rne
    import fp64_pkg::*;
(
    input  logic [MAN_W-1:0]      frac_i,
    input  logic                  g_i,
    input  logic                  st_i,
    input  logic signed [E_W-1:0] e_i,
    output logic [EXP_W-1:0]      exp_o,
    output logic [MAN_W-1:0]      frac_o,
    output logic                  overflow_o,
    output logic                  underflow_o,
    output logic                  inexact_o
);

    localparam logic signed [E_W-1:0] E_MAX  = E_W'((2 ** EXP_W) - 1);
    localparam logic signed [E_W-1:0] E_ZERO = '0;

    logic                  inc;
    logic [MAN_W:0]        sum;
    logic signed [E_W-1:0] e_rnd;

    always_comb begin
        // NOTE: every output gets a default before the range checks so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        inc         = g_i & (st_i | frac_i[0]);
        sum         = {1'b0, frac_i} + {{MAN_W{1'b0}}, inc};
        // A carry out of an all-ones fraction leaves frac=0 and bumps the exponent.
        e_rnd       = e_i + $signed({{(E_W-1){1'b0}}, sum[MAN_W]});
        inexact_o   = g_i | st_i;
        overflow_o  = 1'b0;
        underflow_o = 1'b0;
        exp_o       = e_rnd[EXP_W-1:0];
        frac_o      = sum[MAN_W-1:0];

        if (e_rnd >= E_MAX) begin
            overflow_o = 1'b1;
            inexact_o  = 1'b1;
            exp_o      = INF_EXP;
            frac_o     = '0;
        end else if (e_rnd <= E_ZERO) begin
            // No subnormal support: anything below the normal range flushes to zero.
            underflow_o = 1'b1;
            inexact_o   = 1'b1;
            exp_o       = '0;
            frac_o      = '0;
        end
    end

endmodule

// File: rtl/fp64_mul_norm_round.sv
// -----------------------------------------------------------------------------
// fp64_mul_norm_round
// Final stage of the binary64 multiplier. Stage 1 normalises the 106-bit
// significand product and removes the bias; stage 2 rounds to nearest-even,
// resolves specials and registers the packed result. valid/ready on both sides,
// full throughput, two-cycle latency.
//   clk, rst_n              : clock, asynchronous active-low reset
//   in_valid/in_ready       : input handshake
//   sign_in, exp_sum        : result sign, ea+eb (biased twice)
//   man_prod                : {1,fa}*{1,fb}
//   zero_in/inf_in/nan_in   : operand special-case indications
//   out_valid/out_ready     : output handshake
//   result, flags           : packed binary64, {invalid, overflow, underflow, inexact}
// -----------------------------------------------------------------------------
module fp64_mul_norm_round
    import fp64_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign_in,
    input  logic [EXP_W:0]    exp_sum,
    input  logic [PROD_W-1:0] man_prod,
    input  logic              zero_in,
    input  logic              inf_in,
    input  logic              nan_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       result,
    output logic [3:0]        flags
);

    logic        s1_valid_q;
    s1_t         s1_d, s1_q;
    logic        out_valid_q;
    logic [63:0] result_d, result_q;
    logic [3:0]  flags_d, flags_q;
    logic        s2_load;
    logic        norm;

    logic [EXP_W-1:0] rnd_exp;
    logic [MAN_W-1:0] rnd_frac;
    logic             rnd_ovf, rnd_unf, rnd_inx;

    // Output register loads whenever it is empty or being drained; stage 1
    // can accept whenever it is empty or moving into the output register.
    assign s2_load  = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_load;

    // ---------------- Stage 1: normalise ----------------
    always_comb begin
        s1_d         = '0;
        norm         = man_prod[PROD_W-1];   // product in [2,4): shift right by one
        s1_d.sign    = sign_in;
        s1_d.cls     = classify(nan_in, inf_in, zero_in);
        s1_d.invalid = inf_in & zero_in;
        if (norm) begin
            s1_d.frac = man_prod[PROD_W-2 -: MAN_W];
            s1_d.g    = man_prod[PROD_W-2-MAN_W];
            s1_d.st   = |man_prod[PROD_W-3-MAN_W:0];
        end else begin
            s1_d.frac = man_prod[PROD_W-3 -: MAN_W];
            s1_d.g    = man_prod[PROD_W-3-MAN_W];
            s1_d.st   = |man_prod[PROD_W-4-MAN_W:0];
        end
        // Modular 14-bit arithmetic yields the correct two's-complement value.
        s1_d.e = $signed(E_W'(exp_sum) + E_W'(norm) - E_W'(BIAS));
    end

    // ---------------- Stage 2: round and pack ----------------
    fp_round_rne u_round (
        .frac_i      (s1_q.frac),
        .g_i         (s1_q.g),
        .st_i        (s1_q.st),
        .e_i         (s1_q.e),
        .exp_o       (rnd_exp),
        .frac_o      (rnd_frac),
        .overflow_o  (rnd_ovf),
        .underflow_o (rnd_unf),
        .inexact_o   (rnd_inx)
    );

    always_comb begin
        result_d = '0;
        flags_d  = '0;
        unique case (s1_q.cls)
            CLS_NAN: begin
                result_d               = QNAN_64;
                flags_d[FLAG_INVALID]  = s1_q.invalid;
            end
            CLS_INF:  result_d = {s1_q.sign, INF_EXP, {MAN_W{1'b0}}};
            CLS_ZERO: result_d = {s1_q.sign, {(EXP_W+MAN_W){1'b0}}};
            default: begin
                result_d                = {s1_q.sign, rnd_exp, rnd_frac};
                flags_d[FLAG_OVERFLOW]  = rnd_ovf;
                flags_d[FLAG_UNDERFLOW] = rnd_unf;
                flags_d[FLAG_INEXACT]   = rnd_inx;
            end
        endcase
    end

    // ---------------- Control and output registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge values of the others; the handshake depends on that.
            if (in_ready)
                s1_valid_q <= in_valid;
            if (s2_load) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    result_q <= result_d;
                    flags_q  <= flags_d;
                end
            end
        end
    end

    // NOTE: the stage-1 payload is qualified by s1_valid_q, so it needs no reset;
    // leaving it out keeps the wide data flops plain enable registers.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready)
            s1_q <= s1_d;
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp64_mul_norm_round.sv
module tb_fp64_mul_norm_round;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         sign_in = 1'b0;
    logic [11:0]  exp_sum = '0;
    logic [105:0] man_prod = '0;
    logic         zero_in = 1'b0;
    logic         inf_in = 1'b0;
    logic         nan_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [63:0]  result;
    logic [3:0]   flags;

    always #5 clk = ~clk;

    fp64_mul_norm_round dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_in   (sign_in),
        .exp_sum   (exp_sum),
        .man_prod  (man_prod),
        .zero_in   (zero_in),
        .inf_in    (inf_in),
        .nan_in    (nan_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    typedef struct {
        string        name;
        logic         sign;
        logic [11:0]  exp_sum;
        logic [105:0] prod;
        logic         zero;
        logic         inf;
        logic         nan;
        logic [63:0]  res;
        logic [3:0]   fl;
    } vec_t;

    typedef struct {
        string       name;
        logic [63:0] res;
        logic [3:0]  fl;
    } exp_t;

    localparam logic [105:0] P_ONE  = 106'd1 << 104;
    localparam logic [105:0] P_ALL1 = (106'd1 << 105) - 106'd1;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_out = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic s, input logic [11:0] es,
                       input logic [105:0] p, input logic z, input logic i, input logic n,
                       input logic [63:0] r, input logic [3:0] f);
        vec_t v;
        v.name = name; v.sign = s; v.exp_sum = es; v.prod = p;
        v.zero = z; v.inf = i; v.nan = n; v.res = r; v.fl = f;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        sign_in  = v.sign;
        exp_sum  = v.exp_sum;
        man_prod = v.prod;
        zero_in  = v.zero;
        inf_in   = v.inf;
        nan_in   = v.nan;
        in_valid = 1'b1;
    endtask

    task automatic push(input vec_t v);
        exp_t e;
        e.name = v.name; e.res = v.res; e.fl = v.fl;
        sb.push_back(e);
    endtask

    // Holds a beat on the input until accepted; entered and left at posedge+1.
    task automatic send(input vec_t v);
        bit ok = 0;
        int budget = 0;
        drive(v);
        while (!ok && budget < 200) begin
            @(negedge clk);
            if (in_ready) begin
                push(v);
                ok = 1;
            end
            @(posedge clk); #1;
            budget++;
        end
        in_valid = 1'b0;
        if (!ok) check({"accept timeout ", v.name}, 64'd0, 64'd1);
    endtask

    task automatic wait_drain(input string name);
        int budget = 0;
        while (sb.size() != 0 && budget < 50) begin
            @(posedge clk); #2;
            budget++;
        end
        check(name, 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard: compare every delivered result against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                check("unexpected output", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, " result"}, result, e.res);
                check({e.name, " flags"}, 64'(flags), 64'(e.fl));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int acc;
        int out0;

        //   name            sign exp_sum prod                                   z  i  n  result                   flags
        add("one_x_one",     0, 12'd2046, P_ONE,                               0, 0, 0, 64'h3FF0_0000_0000_0000, 4'b0000);
        add("1p5_x_1p5",     0, 12'd2046, 106'd9 << 102,                       0, 0, 0, 64'h4002_0000_0000_0000, 4'b0000);
        add("tie_even",      0, 12'd2046, P_ONE | (106'd1 << 51),              0, 0, 0, 64'h3FF0_0000_0000_0000, 4'b0001);
        add("tie_odd",       0, 12'd2046, P_ONE | (106'd3 << 51),              0, 0, 0, 64'h3FF0_0000_0000_0002, 4'b0001);
        add("carry_out",     0, 12'd2046, P_ALL1,                              0, 0, 0, 64'h4000_0000_0000_0000, 4'b0001);
        add("overflow",      0, 12'd4000, P_ONE,                               0, 0, 0, 64'h7FF0_0000_0000_0000, 4'b0101);
        add("underflow",     0, 12'd1000, P_ONE,                               0, 0, 0, 64'h0000_0000_0000_0000, 4'b0011);
        add("inf_x_zero",    0, 12'd0,    106'd0,                              1, 1, 0, 64'h7FF8_0000_0000_0000, 4'b1000);
        add("nan",           1, 12'd2046, P_ONE,                               0, 0, 1, 64'h7FF8_0000_0000_0000, 4'b0000);
        add("neg_inf",       1, 12'd2046, P_ONE,                               0, 1, 0, 64'hFFF0_0000_0000_0000, 4'b0000);
        add("neg_zero",      1, 12'd2046, P_ONE,                               1, 0, 0, 64'h8000_0000_0000_0000, 4'b0000);
        add("round_to_inf",  0, 12'd3069, P_ALL1,                              0, 0, 0, 64'h7FF0_0000_0000_0000, 4'b0101);
        add("max_exp",       0, 12'd3069, P_ONE,                               0, 0, 0, 64'h7FE0_0000_0000_0000, 4'b0000);
        add("min_exp",       0, 12'd1024, P_ONE,                               0, 0, 0, 64'h0010_0000_0000_0000, 4'b0000);
        add("exp_zero",      0, 12'd1023, P_ONE,                               0, 0, 0, 64'h0000_0000_0000_0000, 4'b0011);
        add("neg_1p5_sq",    1, 12'd2046, 106'd9 << 102,                       0, 0, 0, 64'hC002_0000_0000_0000, 4'b0000);
        add("n1_sticky",     0, 12'd2046, (106'd1 << 105) | (106'd1 << 52) | 106'd1, 0, 0, 0, 64'h4000_0000_0000_0001, 4'b0001);

        // Reset state.
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset result",    result,         64'd0);
        check("reset flags",     64'(flags),     64'd0);
        check("reset in_ready",  64'(in_ready),  64'd1);
        @(posedge clk); #1;

        // Latency on an idle pipe.
        send(vecs[0]);
        lat = 1;
        while (lat < 10) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'd2);
        @(posedge clk); #1;
        wait_drain("drain latency");

        // Table of vectors, back-to-back.
        @(posedge clk); #1;
        foreach (vecs[i]) send(vecs[i]);
        wait_drain("drain table");

        // Backpressure: four beats offered with the output stalled.
        @(posedge clk); #1;
        out_ready = 1'b0;
        acc = 0;
        out0 = n_out;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (acc < 4) drive(vecs[acc]);
            else in_valid = 1'b0;
            @(negedge clk);
            if (in_valid && in_ready) begin
                push(vecs[acc]);
                acc++;
            end
            if (cyc == 3) check("stall result held A", result, vecs[0].res);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("stall accepted", 64'(acc), 64'd2);
        @(negedge clk);
        check("stall in_ready",  64'(in_ready),  64'd0);
        check("stall out_valid", 64'(out_valid), 64'd1);
        check("stall result held B", result, vecs[0].res);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(vecs[2]);
        send(vecs[3]);
        wait_drain("drain backpressure");
        check("backpressure outputs", 64'(n_out - out0), 64'd4);

        // Reset asserted mid-stream.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(vecs[5]);
        send(vecs[6]);
        #1 rst_n = 1'b0;
        #1;
        check("midreset out_valid", 64'(out_valid), 64'd0);
        check("midreset in_ready",  64'(in_ready),  64'd1);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post reset out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        out0 = n_out;
        send(vecs[1]);
        wait_drain("drain after reset");
        check("post reset outputs", 64'(n_out - out0), 64'd1);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
